vga_frame_capture: RTL and testbench

Video-input counterpart of the VGA output subsystem. Decodes a VGA-style pixel stream (BLANK_N, HS, VS, 8-bit R/G/B, sampled on the pixel clock) into frame/pixel positions. Buffers active pixels in a small FIFO. Writes them as a linear frame buffer into SDRAM through an Avalon-MM write master. Sits beside the SDRAM controller in the system and is clocked by the pixel clock.

---
 rtl/vga_frame_capture.sv | 276 +++++++++++++++++++++++++++
 tb/tb_vga_frame_capture.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_capture.sv
// vga_frame_capture
// Captures a VGA-style pixel stream (BLANK_N/HS/VS + 8-bit R/G/B on the pixel
// clock) into a linear frame buffer in SDRAM through an Avalon-MM write master.
// Active pixels are tagged with their frame index, buffered in a small FIFO and
// written one entry per accepted Avalon transfer.
// Build option: define VGA_CAPTURE_RGB888_EN for 32-bit {8'h00,R,G,B} pixels
// with a 4-byte stride; without it pixels are RGB565 with a 2-byte stride.
module vga_frame_capture #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        vid_blank_n,
  input  logic        vid_hs,
  input  logic        vid_vs,
  input  logic [7:0]  vid_r,
  input  logic [7:0]  vid_g,
  input  logic [7:0]  vid_b,
  output logic [31:0] avm_address,
  output logic        avm_write,
`ifdef VGA_CAPTURE_RGB888_EN
  output logic [31:0] avm_writedata,
`else
  output logic [15:0] avm_writedata,
`endif
  input  logic        avm_waitrequest,
  output logic        frame_done,
  output logic        overflow,
  output logic        frame_err,
  input  logic        clr_status
);

`ifdef VGA_CAPTURE_RGB888_EN
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_SH = 2;
`else
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_SH = 1;
`endif
  localparam int unsigned NPIX  = H_ACTIVE * V_ACTIVE;
  localparam int unsigned IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = IDX_W + DATA_W;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NPIX - 1);
  localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SYNC    = 2'd1,
    S_CAPTURE = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  // Control and status registers
  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_vs_q;
  logic               r_restart;
  logic               r_frame_done;
  logic               r_overflow;
  logic               r_frame_err;

  // Sample stage (one entry, pushed into the FIFO on the following edge)
  logic               r_in_valid;
  logic [ENT_W-1:0]   r_in_entry;

  // FIFO storage and pointers
  logic [ENT_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;

  // Avalon master output registers
  logic               r_avm_write;
  logic [31:0]        r_avm_address;
  logic [DATA_W-1:0]  r_avm_writedata;

  logic [DATA_W-1:0]  w_pix_data;
  logic               w_unused;
  logic               w_vs_fall;
  logic               w_sample;
  logic               w_last;
  logic               w_short;
  logic               w_accept;
  logic               w_out_free;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic               w_drain_done;
  logic [CNT_W:0]     w_occ;
  logic [ENT_W-1:0]   w_head;
  logic [IDX_W-1:0]   w_head_idx;
  logic [DATA_W-1:0]  w_head_data;
  logic [31:0]        w_head_addr;

`ifdef VGA_CAPTURE_RGB888_EN
  assign w_pix_data = {8'h00, vid_r, vid_g, vid_b};
  assign w_unused   = vid_hs;
`else
  assign w_pix_data = {vid_r[7:3], vid_g[7:2], vid_b[7:3]};
  assign w_unused   = ^{vid_hs, vid_r[2:0], vid_g[1:0], vid_b[2:0]};
`endif

  // A frame starts on the high-to-low transition of VS.
  assign w_vs_fall = r_vs_q & ~vid_vs;
  assign w_sample  = (r_state == S_CAPTURE) & vid_blank_n;
  assign w_last    = w_sample & (r_idx == LAST_IDX);
  // VS ahead of the last pixel ends the frame early; completing wins a tie.
  assign w_short   = (r_state == S_CAPTURE) & w_vs_fall & ~w_last;

  assign w_accept   = r_avm_write & ~avm_waitrequest;
  assign w_out_free = ~r_avm_write | ~avm_waitrequest;
  assign w_pop      = w_out_free & (r_count != {CNT_W{1'b0}});

  // Capacity counts the queued entries plus the one held on the bus, so a
  // stalled slave backs pressure up after FIFO_DEPTH pixels in total.
  assign w_occ  = {1'b0, r_count} + {{CNT_W{1'b0}}, r_avm_write};
  assign w_push = r_in_valid & ((w_occ < DEPTH_OCC) | w_accept);
  assign w_drop = r_in_valid & ~w_push;

  assign w_drain_done = (r_count == {CNT_W{1'b0}}) & ~r_in_valid &
                        (~r_avm_write | w_accept);

  assign w_head      = r_mem[r_rptr];
  assign w_head_idx  = w_head[ENT_W-1:DATA_W];
  assign w_head_data = w_head[DATA_W-1:0];
  // Address arithmetic is 32-bit and wraps naturally.
  assign w_head_addr = BASE_ADDR + (32'(w_head_idx) << ADDR_SH);

  // Frame sequencing: state, pixel index, VS edge history, done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_idx        <= {IDX_W{1'b0}};
      r_vs_q       <= 1'b0;
      r_restart    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_vs_q       <= vid_vs;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state <= S_SYNC;
          end
        end
        S_SYNC: begin
          if (!enable) begin
            r_state <= S_IDLE;
          end else if (w_vs_fall) begin
            r_state <= S_CAPTURE;
            r_idx   <= {IDX_W{1'b0}};
          end
        end
        S_CAPTURE: begin
          if (w_sample) begin
            r_idx <= r_idx + IDX_W'(1);
          end
          if (w_last) begin
            r_state   <= S_DRAIN;
            r_restart <= 1'b0;
          end else if (w_short) begin
            // The early VS edge is also the start of the next frame.
            r_state   <= S_DRAIN;
            r_restart <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_drain_done) begin
            r_frame_done <= 1'b1;
            r_restart    <= 1'b0;
            if (!enable) begin
              r_state <= S_IDLE;
            end else if (r_restart) begin
              r_state <= S_CAPTURE;
              r_idx   <= {IDX_W{1'b0}};
            end else begin
              r_state <= S_SYNC;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Sample stage: tag each captured active pixel with its frame index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_valid <= 1'b0;
      r_in_entry <= {ENT_W{1'b0}};
    end else begin
      r_in_valid <= w_sample;
      if (w_sample) begin
        r_in_entry <= {r_idx, w_pix_data};
      end
    end
  end

  // FIFO storage; contents need no reset because the count gates reads.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= r_in_entry;
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= {PTR_W{1'b0}};
      r_rptr  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Avalon write master: present the FIFO head, hold it while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_avm_write     <= 1'b0;
      r_avm_address   <= 32'h0000_0000;
      r_avm_writedata <= {DATA_W{1'b0}};
    end else if (w_pop) begin
      r_avm_write     <= 1'b1;
      r_avm_address   <= w_head_addr;
      r_avm_writedata <= w_head_data;
    end else if (w_accept) begin
      r_avm_write     <= 1'b0;
    end
  end

  // Sticky status flags; a set event beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_status) begin
        r_overflow <= 1'b0;
      end
      if (w_short) begin
        r_frame_err <= 1'b1;
      end else if (clr_status) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  assign avm_write     = r_avm_write;
  assign avm_address   = r_avm_address;
  assign avm_writedata = r_avm_writedata;
  assign frame_done    = r_frame_done;
  assign overflow      = r_overflow;
  assign frame_err     = r_frame_err;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Testbench for vga_frame_capture (RGB565 build): a 4x2 frame at base 0x1000
// with a 4-entry FIFO. A negedge-driven Avalon slave model records accepted
// writes and can stall the bus; frames are described by a vector table.
module tb_vga_frame_capture;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        vid_blank_n = 1'b0;
  logic        vid_hs = 1'b1;
  logic        vid_vs = 1'b1;
  logic [7:0]  vid_r = 8'h00;
  logic [7:0]  vid_g = 8'h00;
  logic [7:0]  vid_b = 8'h00;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [15:0] avm_writedata;
  logic        avm_waitrequest = 1'b0;
  logic        frame_done;
  logic        overflow;
  logic        frame_err;
  logic        clr_status = 1'b0;

  vga_frame_capture #(
    .H_ACTIVE   (4),
    .V_ACTIVE   (2),
    .BASE_ADDR  (32'h0000_1000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .vid_blank_n     (vid_blank_n),
    .vid_hs          (vid_hs),
    .vid_vs          (vid_vs),
    .vid_r           (vid_r),
    .vid_g           (vid_g),
    .vid_b           (vid_b),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .frame_done      (frame_done),
    .overflow        (overflow),
    .frame_err       (frame_err),
    .clr_status      (clr_status)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_done = 0;
  int n_wr_seen = 0;
  int last_acc_cyc = -10;
  int hold_cnt = 0;
  int stall_at = -1;
  int stall_left = 0;
  logic [31:0] st_exp_addr = 32'h0;
  logic [31:0] st_exp_data = 32'h0;
  logic [31:0] acc_addr [64];
  logic [15:0] acc_data [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Avalon slave model: drives waitrequest, records accepted writes.
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      avm_waitrequest = 1'b0;
    end else begin
      if (hold_cnt > 0) begin
        avm_waitrequest = 1'b1;
        hold_cnt--;
      end else if (avm_write && n_acc == stall_at && stall_left > 0) begin
        avm_waitrequest = 1'b1;
        check("stall_addr_stable", avm_address, st_exp_addr);
        check("stall_data_stable", 32'(avm_writedata), st_exp_data);
        stall_left--;
      end else begin
        avm_waitrequest = 1'b0;
      end
      if (avm_write) n_wr_seen++;
      if (avm_write && !avm_waitrequest) begin
        if (n_acc < 64) begin
          acc_addr[n_acc] = avm_address;
          acc_data[n_acc] = avm_writedata;
        end
        n_acc++;
        last_acc_cyc = cyc;
      end
      if (frame_done) begin
        n_done++;
        check("done_after_last_accept", 32'(cyc - last_acc_cyc), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_line(input int n, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    vid_r = r;
    vid_g = g;
    vid_b = b;
    for (int i = 0; i < n; i++) begin
      vid_blank_n = 1'b1;
      tick();
    end
    vid_blank_n = 1'b0;
  endtask

  task automatic vs_pulse();
    vid_vs = 1'b0;
    idle(2);
    vid_vs = 1'b1;
    idle(2);
  endtask

  task automatic clear_capture();
    n_acc = 0;
    n_done = 0;
    n_wr_seen = 0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (n_done != 0) break;
      tick();
    end
    idle(4);
  endtask

  task automatic frame_check(input string tag, input int exp_n, input logic [15:0] exp_data,
                             input logic exp_ovf, input logic exp_err);
    check({tag, "_writes"}, 32'(n_acc), 32'(exp_n));
    for (int i = 0; i < exp_n && i < n_acc; i++) begin
      check({tag, "_addr"}, acc_addr[i], 32'h0000_1000 + 32'(2 * i));
      check({tag, "_data"}, 32'(acc_data[i]), 32'(exp_data));
    end
    check({tag, "_done_pulses"}, 32'(n_done), 32'd1);
    check({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    check({tag, "_frame_err"}, 32'(frame_err), 32'(exp_err));
    check({tag, "_bus_idle"}, 32'(avm_write), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    int          gap;       // blank cycles between the two lines
    int          hold;      // cycles waitrequest is forced high from frame start
    int          stall_at;  // write index stalled for 5 cycles, -1 for none
    int          exp_n;
    logic [15:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [4];

  initial begin
    // r, g, b, gap, hold, stall_at, expected writes, expected RGB565, overflow
    vecs[0] = '{8'hF8, 8'hFC, 8'hF8, 4, 0, -1, 8, 16'hFFFF, 1'b0};
    vecs[1] = '{8'h80, 8'h40, 8'h20, 2, 0, -1, 8, 16'h8204, 1'b0};
    vecs[2] = '{8'h18, 8'h0C, 8'h08, 6, 0,  2, 8, 16'h1861, 1'b0};
    vecs[3] = '{8'hF8, 8'h00, 8'h00, 0, 20, -1, 4, 16'hF800, 1'b1};

    // Reset state
    idle(3);
    check("rst_write", 32'(avm_write), 32'd0);
    check("rst_address", avm_address, 32'h0);
    check("rst_data", 32'(avm_writedata), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    reset_n = 1'b1;
    enable = 1'b1;
    idle(3);

    // Table-driven frames
    for (int v = 0; v < 4; v++) begin
      clear_capture();
      hold_cnt = vecs[v].hold;
      stall_at = vecs[v].stall_at;
      stall_left = (vecs[v].stall_at >= 0) ? 5 : 0;
      st_exp_addr = 32'h0000_1000 + 32'(2 * vecs[v].stall_at);
      st_exp_data = 32'(vecs[v].exp_data);
      vs_pulse();
      send_line(4, vecs[v].r, vecs[v].g, vecs[v].b);
      idle(vecs[v].gap);
      send_line(4, vecs[v].r, vecs[v].g, vecs[v].b);
      wait_done(300);
      frame_check($sformatf("vec%0d", v), vecs[v].exp_n, vecs[v].exp_data, vecs[v].exp_ovf, 1'b0);
      if (vecs[v].stall_at >= 0) check("stall_cycles_used", 32'(stall_left), 32'd0);
      if (vecs[v].exp_ovf) begin
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        check("clr_overflow", 32'(overflow), 32'd0);
      end
      stall_at = -1;
      idle(3);
    end

    // Short frame: VS falls after 5 of 8 pixels
    clear_capture();
    vs_pulse();
    send_line(5, 8'hF8, 8'hFC, 8'hF8);
    vs_pulse();
    wait_done(300);
    frame_check("short", 5, 16'hFFFF, 1'b0, 1'b1);

    // Next frame starts capturing straight from the early VS edge
    clear_capture();
    send_line(4, 8'hF8, 8'hFC, 8'hF8);
    idle(2);
    send_line(4, 8'hF8, 8'hFC, 8'hF8);
    wait_done(300);
    frame_check("restart", 8, 16'hFFFF, 1'b0, 1'b1);
    idle(3);

    // Reset in the middle of a stalled write
    clear_capture();
    hold_cnt = 30;
    vs_pulse();
    send_line(4, 8'hF8, 8'hFC, 8'hF8);
    idle(3);
    check("pre_reset_write", 32'(avm_write), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    hold_cnt = 0;
    check("midrst_write", 32'(avm_write), 32'd0);
    check("midrst_address", avm_address, 32'h0);
    check("midrst_data", 32'(avm_writedata), 32'h0);
    check("midrst_frame_done", 32'(frame_done), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    idle(2);
    reset_n = 1'b1;
    clear_capture();
    send_line(4, 8'hF8, 8'hFC, 8'hF8);
    idle(2);
    send_line(4, 8'hF8, 8'hFC, 8'hF8);
    idle(10);
    check("post_reset_no_write", 32'(n_wr_seen), 32'd0);

    // Recovery after reset needs a fresh VS edge
    clear_capture();
    vs_pulse();
    send_line(4, 8'h80, 8'h40, 8'h20);
    idle(2);
    send_line(4, 8'h80, 8'h40, 8'h20);
    wait_done(300);
    frame_check("post_reset", 8, 16'h8204, 1'b0, 1'b0);
    idle(3);

    // Enable dropped mid-frame: frame completes, then no further capture
    clear_capture();
    vs_pulse();
    send_line(3, 8'h18, 8'h0C, 8'h08);
    enable = 1'b0;
    send_line(1, 8'h18, 8'h0C, 8'h08);
    idle(2);
    send_line(4, 8'h18, 8'h0C, 8'h08);
    wait_done(300);
    frame_check("en_drop", 8, 16'h1861, 1'b0, 1'b0);
    clear_capture();
    vs_pulse();
    send_line(4, 8'h18, 8'h0C, 8'h08);
    idle(10);
    check("disabled_no_write", 32'(n_wr_seen), 32'd0);
    check("disabled_no_done", 32'(n_done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
